// File: rtl/lsu_bus.sv
// Load/store unit front-end for an external request/response memory bus.
// Handles byte-lane steering, store strobes, load extension and error/timeout reporting.
module lsu_bus #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic              mem_en,
   input  logic              wen,
   input  logic [2:0]        mtype,
   input  logic [XLEN-1:0]   addr,
   input  logic [XLEN-1:0]   wdata,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [XLEN-1:0]   rdata,
   output logic [1:0]        err,
   output logic              bus_req_valid,
   input  logic              bus_req_ready,
   output logic [XLEN-1:0]   bus_addr,
   output logic              bus_wen,
   output logic [XLEN-1:0]   bus_wdata,
   output logic [XLEN/8-1:0] bus_wstrb,
   input  logic              bus_resp_valid,
   output logic              bus_resp_ready,
   input  logic [XLEN-1:0]   bus_rdata,
   input  logic              bus_resp_err
);

   localparam int unsigned NB = XLEN / 8;
   localparam int unsigned OW = $clog2(NB);

   typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

   // Byte-lane mask of an access, LSB-justified.
   function automatic logic [NB-1:0] lane_mask(input logic [2:0] mt);
      case (mt)
         3'd0, 3'd3: lane_mask = NB'(1);
         3'd1, 3'd4: lane_mask = NB'(3);
         3'd2, 3'd5: lane_mask = NB'(15);
         default:    lane_mask = '1;
      endcase
   endfunction

   // Size minus one, used as the alignment mask on the byte offset.
   function automatic logic [OW-1:0] align_mask(input logic [2:0] mt);
      case (mt)
         3'd0, 3'd3: align_mask = '0;
         3'd1, 3'd4: align_mask = OW'(1);
         3'd2, 3'd5: align_mask = OW'(3);
         default:    align_mask = OW'(7);
      endcase
   endfunction

   state_e            state_q, state_d;
   logic              wen_q, wen_d;
   logic [2:0]        mtype_q, mtype_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;
   logic [1:0]        err_q, err_d;
   logic [31:0]       cnt_q, cnt_d;

   logic [OW-1:0]     in_off, in_amask, off_q;
   logic              in_legal, tmo_hit;
   logic [NB-1:0]     st_mask;
   logic [XLEN-1:0]   lanes, ld_ext;

   // Legality of the incoming access and per-transaction datapath helpers.
   always_comb begin
      in_off   = addr[OW-1:0];
      in_amask = align_mask(mtype);
      in_legal = (mtype != 3'd7) && ((XLEN == 64) || (mtype < 3'd5))
                 && ((in_off & in_amask) == '0);
      off_q    = addr_q[OW-1:0];
      st_mask  = lane_mask(mtype_q);
      tmo_hit  = (TIMEOUT != 0) && ((cnt_q + 32'd1) == TIMEOUT);
   end

   // Load lane alignment followed by sign/zero extension.
   always_comb begin
      lanes = bus_rdata >> {off_q, 3'b000};
      case (mtype_q)
         3'd0:    ld_ext = XLEN'($signed(lanes[7:0]));
         3'd1:    ld_ext = XLEN'($signed(lanes[15:0]));
         3'd2:    ld_ext = XLEN'($signed(lanes[31:0]));
         3'd3:    ld_ext = XLEN'(lanes[7:0]);
         3'd4:    ld_ext = XLEN'(lanes[15:0]);
         3'd5:    ld_ext = XLEN'(lanes[31:0]);
         default: ld_ext = lanes;
      endcase
   end

   // Next-state logic; a response in the timeout cycle wins over the timeout.
   always_comb begin
      state_d = state_q;
      wen_d   = wen_q;
      mtype_d = mtype_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (s_valid) begin
               wen_d   = wen;
               mtype_d = mtype;
               addr_d  = addr;
               wdata_d = wdata;
               rdata_d = '0;
               err_d   = 2'd0;
               cnt_d   = '0;
               if (!mem_en) begin
                  state_d = StDone;
               end else if (!in_legal) begin
                  err_d   = 2'd1;
                  state_d = StDone;
               end else begin
                  state_d = StReq;
               end
            end
         end
         StReq: begin
            cnt_d = cnt_q + 32'd1;
            if (tmo_hit) begin
               err_d   = 2'd3;
               rdata_d = '0;
               state_d = StDone;
            end else if (bus_req_ready) begin
               state_d = StResp;
            end
         end
         StResp: begin
            cnt_d = cnt_q + 32'd1;
            if (bus_resp_valid) begin
               err_d   = bus_resp_err ? 2'd2 : 2'd0;
               rdata_d = wen_q ? '0 : ld_ext;
               state_d = StDone;
            end else if (tmo_hit) begin
               err_d   = 2'd3;
               rdata_d = '0;
               state_d = StDone;
            end
         end
         StDone: begin
            if (m_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and transaction registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         wen_q   <= 1'b0;
         mtype_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         wen_q   <= wen_d;
         mtype_q <= mtype_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // Handshake and bus outputs decoded from the state and held registers.
   always_comb begin
      s_ready        = (state_q == StIdle);
      m_valid        = (state_q == StDone);
      bus_req_valid  = (state_q == StReq);
      bus_resp_ready = (state_q == StResp);
      rdata          = rdata_q;
      err            = err_q;
      bus_addr       = {addr_q[XLEN-1:OW], {OW{1'b0}}};
      bus_wen        = wen_q;
      bus_wdata      = wdata_q << {off_q, 3'b000};
      bus_wstrb      = wen_q ? (st_mask << off_q) : '0;
   end

endmodule

// File: tb/tb_lsu_bus.sv
// Directed bench for lsu_bus: a 32-bit and a 64-bit instance, both with TIMEOUT=4.
module tb_lsu_bus;

   logic        clk = 1'b0;
   logic        rst;
   logic        sv32, sv64, sel64;
   logic        mem_en, wen, m_ready;
   logic [2:0]  mtype;
   logic [63:0] addr, wdata, bus_rdata;
   logic        bus_req_ready, bus_resp_valid, bus_resp_err;

   logic        s_ready32, m_valid32, breqv32, bwen32, brespr32;
   logic [31:0] rdata32, baddr32, bwdata32;
   logic [1:0]  err32;
   logic [3:0]  bwstrb32;
   logic        s_ready64, m_valid64, breqv64, bwen64, brespr64;
   logic [63:0] rdata64, baddr64, bwdata64;
   logic [1:0]  err64;
   logic [7:0]  bwstrb64;

   logic        o_sready, o_mvalid, o_breqv, o_bwen, o_brespr;
   logic [63:0] o_rdata, o_baddr, o_bwdata;
   logic [1:0]  o_err;
   logic [7:0]  o_bwstrb;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   lsu_bus #(.XLEN(32), .TIMEOUT(4)) u_dut32 (
      .clk(clk), .rst(rst), .s_valid(sv32), .s_ready(s_ready32), .mem_en(mem_en), .wen(wen),
      .mtype(mtype), .addr(addr[31:0]), .wdata(wdata[31:0]), .m_valid(m_valid32),
      .m_ready(m_ready), .rdata(rdata32), .err(err32), .bus_req_valid(breqv32),
      .bus_req_ready(bus_req_ready), .bus_addr(baddr32), .bus_wen(bwen32),
      .bus_wdata(bwdata32), .bus_wstrb(bwstrb32), .bus_resp_valid(bus_resp_valid),
      .bus_resp_ready(brespr32), .bus_rdata(bus_rdata[31:0]), .bus_resp_err(bus_resp_err)
   );

   lsu_bus #(.XLEN(64), .TIMEOUT(4)) u_dut64 (
      .clk(clk), .rst(rst), .s_valid(sv64), .s_ready(s_ready64), .mem_en(mem_en), .wen(wen),
      .mtype(mtype), .addr(addr), .wdata(wdata), .m_valid(m_valid64),
      .m_ready(m_ready), .rdata(rdata64), .err(err64), .bus_req_valid(breqv64),
      .bus_req_ready(bus_req_ready), .bus_addr(baddr64), .bus_wen(bwen64),
      .bus_wdata(bwdata64), .bus_wstrb(bwstrb64), .bus_resp_valid(bus_resp_valid),
      .bus_resp_ready(brespr64), .bus_rdata(bus_rdata), .bus_resp_err(bus_resp_err)
   );

   // View of whichever instance is under test.
   always_comb begin
      if (sel64) begin
         o_sready = s_ready64; o_mvalid = m_valid64; o_breqv = breqv64; o_bwen = bwen64;
         o_brespr = brespr64;  o_rdata = rdata64;    o_baddr = baddr64;  o_bwdata = bwdata64;
         o_err = err64;        o_bwstrb = bwstrb64;
      end else begin
         o_sready = s_ready32; o_mvalid = m_valid32; o_breqv = breqv32; o_bwen = bwen32;
         o_brespr = brespr32;  o_rdata = {32'd0, rdata32}; o_baddr = {32'd0, baddr32};
         o_bwdata = {32'd0, bwdata32}; o_err = err32; o_bwstrb = {4'd0, bwstrb32};
      end
   end

   typedef struct {
      logic        x64;
      logic        mem_en;
      logic        wen;
      logic [2:0]  mtype;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] brd;
      logic        rerr;
      int          lat;
      logic [1:0]  err;
      logic [63:0] rdata;
      logic        bus;
      logic [63:0] baddr;
      logic [63:0] bwdata;
      logic [7:0]  strb;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic x64, input logic me, input logic w,
                               input logic [2:0] mt, input logic [63:0] a, input logic [63:0] wd,
                               input logic [63:0] brd, input logic rerr, input int lat,
                               input logic [1:0] e, input logic [63:0] rd, input logic bus,
                               input logic [63:0] ba, input logic [63:0] bwd,
                               input logic [7:0] st);
      vec_t v;
      v.x64 = x64; v.mem_en = me; v.wen = w; v.mtype = mt; v.addr = a; v.wdata = wd;
      v.brd = brd; v.rerr = rerr; v.lat = lat; v.err = e; v.rdata = rd; v.bus = bus;
      v.baddr = ba; v.bwdata = bwd; v.strb = st;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Issue one transaction with an always-ready bus and downstream.
   task automatic run_vec(input int idx, input vec_t v);
      int          lat;
      logic        got_req;
      logic [63:0] cap_addr, cap_wdata;
      logic [7:0]  cap_strb;
      logic        cap_wen;
      got_req = 1'b0; cap_addr = '0; cap_wdata = '0; cap_strb = '0; cap_wen = 1'b0;
      @(negedge clk);
      sel64 = v.x64; mem_en = v.mem_en; wen = v.wen; mtype = v.mtype; addr = v.addr;
      wdata = v.wdata; bus_rdata = v.brd; bus_resp_err = v.rerr;
      if (v.x64) sv64 = 1'b1; else sv32 = 1'b1;
      @(posedge clk); #1;
      sv32 = 1'b0; sv64 = 1'b0;
      lat = 1;
      while (!o_mvalid && lat < 20) begin
         if (o_breqv) begin
            got_req = 1'b1; cap_addr = o_baddr; cap_wdata = o_bwdata;
            cap_strb = o_bwstrb; cap_wen = o_bwen;
         end
         @(posedge clk); #1;
         lat++;
      end
      check($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.lat));
      check($sformatf("v%0d_rdata", idx), o_rdata, v.rdata);
      check($sformatf("v%0d_err", idx), 64'(o_err), 64'(v.err));
      check($sformatf("v%0d_bus_activity", idx), 64'(got_req), 64'(v.bus));
      if (v.bus) begin
         check($sformatf("v%0d_bus_addr", idx), cap_addr, v.baddr);
         check($sformatf("v%0d_bus_wdata", idx), cap_wdata, v.bwdata);
         check($sformatf("v%0d_bus_wstrb", idx), 64'(cap_strb), 64'(v.strb));
         check($sformatf("v%0d_bus_wen", idx), 64'(cap_wen), 64'(v.wen));
      end
      @(posedge clk); #1;
      check($sformatf("v%0d_back_idle", idx), 64'(o_sready), 64'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_s_ready"}, 64'(o_sready), 64'd1);
      check({tag, "_m_valid"}, 64'(o_mvalid), 64'd0);
      check({tag, "_rdata"}, o_rdata, 64'd0);
      check({tag, "_err"}, 64'(o_err), 64'd0);
      check({tag, "_req_valid"}, 64'(o_breqv), 64'd0);
      check({tag, "_resp_ready"}, 64'(o_brespr), 64'd0);
   endtask

   // Drive one request into the 32-bit instance and stop right after the accept edge.
   task automatic start32(input logic [2:0] mt, input logic [63:0] a, input logic [63:0] brd);
      @(negedge clk);
      sel64 = 1'b0; mem_en = 1'b1; wen = 1'b0; mtype = mt; addr = a; wdata = '0;
      bus_rdata = brd; bus_resp_err = 1'b0; sv32 = 1'b1;
      @(posedge clk); #1;
      sv32 = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b0; sv32 = 1'b0; sv64 = 1'b0; sel64 = 1'b0; mem_en = 1'b0; wen = 1'b0;
      mtype = '0; addr = '0; wdata = '0; bus_rdata = '0; m_ready = 1'b1;
      bus_req_ready = 1'b1; bus_resp_valid = 1'b1; bus_resp_err = 1'b0;

      // x64, mem_en, wen, mtype, addr, wdata, bus_rdata, resp_err,
      // latency, err, rdata, bus?, bus_addr, bus_wdata, wstrb
      vecs.push_back(mk(0,1,0,3'd0,64'h1003,64'h0,64'h80FF_FFFF,0, 3,2'd0,64'hFFFF_FF80,1,64'h1000,64'h0,8'h0));
      vecs.push_back(mk(0,1,0,3'd3,64'h1003,64'h0,64'h80FF_FFFF,0, 3,2'd0,64'h80,1,64'h1000,64'h0,8'h0));
      vecs.push_back(mk(0,1,1,3'd1,64'h2002,64'hBEEF,64'hFFFF_FFFF,0, 3,2'd0,64'h0,1,64'h2000,64'hBEEF_0000,8'hC));
      vecs.push_back(mk(0,1,0,3'd2,64'h1002,64'h0,64'h0,0, 1,2'd1,64'h0,0,64'h0,64'h0,8'h0));
      vecs.push_back(mk(0,0,0,3'd2,64'h1000,64'h55,64'hFFFF_FFFF,0, 1,2'd0,64'h0,0,64'h0,64'h0,8'h0));
      vecs.push_back(mk(0,1,0,3'd5,64'h1000,64'h0,64'hFFFF_FFFF,0, 1,2'd1,64'h0,0,64'h0,64'h0,8'h0));
      vecs.push_back(mk(0,1,0,3'd7,64'h0,64'h0,64'hFFFF_FFFF,0, 1,2'd1,64'h0,0,64'h0,64'h0,8'h0));
      vecs.push_back(mk(0,1,0,3'd1,64'h1002,64'h0,64'h8001_1234,0, 3,2'd0,64'hFFFF_8001,1,64'h1000,64'h0,8'h0));
      vecs.push_back(mk(0,1,0,3'd4,64'h0,64'h0,64'h1234_8765,0, 3,2'd0,64'h8765,1,64'h0,64'h0,8'h0));
      vecs.push_back(mk(0,1,1,3'd2,64'h0,64'h1234_5678,64'hFFFF_FFFF,0, 3,2'd0,64'h0,1,64'h0,64'h1234_5678,8'hF));
      vecs.push_back(mk(0,1,0,3'd2,64'h0,64'h0,64'h1122_3344,1, 3,2'd2,64'h1122_3344,1,64'h0,64'h0,8'h0));
      vecs.push_back(mk(0,1,1,3'd0,64'h3,64'hA5,64'hFFFF_FFFF,0, 3,2'd0,64'h0,1,64'h0,64'hA500_0000,8'h8));
      vecs.push_back(mk(1,1,0,3'd6,64'h8,64'h0,64'h0123_4567_89AB_CDEF,0, 3,2'd0,64'h0123_4567_89AB_CDEF,1,64'h8,64'h0,8'h0));
      vecs.push_back(mk(1,1,0,3'd5,64'hC,64'h0,64'hF000_0000_0000_0000,0, 3,2'd0,64'h0000_0000_F000_0000,1,64'h8,64'h0,8'h0));
      vecs.push_back(mk(1,1,0,3'd2,64'hC,64'h0,64'hF000_0000_0000_0000,0, 3,2'd0,64'hFFFF_FFFF_F000_0000,1,64'h8,64'h0,8'h0));
      vecs.push_back(mk(1,1,1,3'd0,64'h5,64'hAB,64'hFFFF_FFFF_FFFF_FFFF,0, 3,2'd0,64'h0,1,64'h0,64'h0000_AB00_0000_0000,8'h20));
      vecs.push_back(mk(1,1,1,3'd2,64'h4,64'hDEAD_BEEF,64'h0,0, 3,2'd0,64'h0,1,64'h0,64'hDEAD_BEEF_0000_0000,8'hF0));
      vecs.push_back(mk(1,1,1,3'd6,64'h14,64'h1,64'h0,0, 1,2'd1,64'h0,0,64'h0,64'h0,8'h0));
      vecs.push_back(mk(1,1,0,3'd7,64'h0,64'h0,64'h0,0, 1,2'd1,64'h0,0,64'h0,64'h0,8'h0));
      vecs.push_back(mk(1,1,0,3'd1,64'h6,64'h0,64'h8000_1111_2222_3333,0, 3,2'd0,64'hFFFF_FFFF_FFFF_8000,1,64'h0,64'h0,8'h0));

      // Reset values on both instances.
      #12;
      sel64 = 1'b0; #1; check_reset_outputs("rst32");
      sel64 = 1'b1; #1; check_reset_outputs("rst64");
      @(negedge clk);
      rst = 1'b1;

      foreach (vecs[i]) run_vec(i, vecs[i]);

      // Illegal access held in DONE by downstream back-pressure.
      m_ready = 1'b0;
      start32(3'd2, 64'h1002, 64'h0);
      check("hold_mvalid0", 64'(o_mvalid), 64'd1);
      check("hold_err0", 64'(o_err), 64'd1);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         check($sformatf("hold_mvalid%0d", k + 1), 64'(o_mvalid), 64'd1);
         check($sformatf("hold_err%0d", k + 1), 64'(o_err), 64'd1);
         check($sformatf("hold_sready%0d", k + 1), 64'(o_sready), 64'd0);
         check($sformatf("hold_reqv%0d", k + 1), 64'(o_breqv), 64'd0);
      end
      m_ready = 1'b1;
      @(posedge clk); #1;
      check("hold_release_sready", 64'(o_sready), 64'd1);
      check("hold_release_mvalid", 64'(o_mvalid), 64'd0);

      // Request never accepted: times out after four cycles in REQ.
      bus_req_ready = 1'b0;
      start32(3'd2, 64'h100, 64'h1234_5678);
      n = 0;
      while (o_breqv && n < 20) begin
         n++;
         @(posedge clk); #1;
      end
      check("tmo_req_cycles", 64'(n), 64'd4);
      check("tmo_mvalid", 64'(o_mvalid), 64'd1);
      check("tmo_err", 64'(o_err), 64'd3);
      check("tmo_rdata", o_rdata, 64'd0);
      bus_req_ready = 1'b1;
      @(posedge clk); #1;
      check("tmo_back_idle", 64'(o_sready), 64'd1);

      // Response arrives in the very cycle the counter expires: response wins.
      bus_resp_valid = 1'b0;
      start32(3'd2, 64'h40, 64'hCAFE_F00D);
      repeat (3) begin @(posedge clk); #1; end
      check("prio_in_resp", 64'(o_brespr), 64'd1);
      bus_resp_valid = 1'b1;
      @(posedge clk); #1;
      check("prio_mvalid", 64'(o_mvalid), 64'd1);
      check("prio_err", 64'(o_err), 64'd0);
      check("prio_rdata", o_rdata, 64'hCAFE_F00D);
      @(posedge clk); #1;

      // Asynchronous reset while waiting for a response.
      bus_resp_valid = 1'b0;
      start32(3'd2, 64'h80, 64'h0);
      @(posedge clk); #1;
      check("arst_in_resp", 64'(o_brespr), 64'd1);
      #2 rst = 1'b0;
      #1 check_reset_outputs("arst");
      @(negedge clk);
      rst = 1'b1;
      bus_resp_valid = 1'b1;
      run_vec(100, vecs[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
